// File: rtl/ysyx_22051013_imem_resp_pkg.sv
// rtl/ysyx_22051013_imem_resp_pkg.sv - shared widths and FSM encoding for the instruction response buffer
package ysyx_22051013_imem_resp_pkg;

  localparam int unsigned YSYX_22051013_PC   = 64;
  localparam int unsigned YSYX_22051013_INST = 32;
  localparam int unsigned YSYX_22051013_LINE = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } imem_state_e;

  function automatic logic [YSYX_22051013_PC-1:0] line_addr(input logic [YSYX_22051013_PC-1:0] pc);
    return {pc[YSYX_22051013_PC-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/ysyx_22051013_imem_resp.sv
// rtl/ysyx_22051013_imem_resp.sv - single-entry fetch buffer with one-outstanding memory read FSM
// Optional macro ysyx_22051013_IMEM_LBUF_EN: tag the buffer by 8-byte line instead of full pc.
module ysyx_22051013_imem_resp
  import ysyx_22051013_imem_resp_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [YSYX_22051013_PC-1:0]   pc_i,
  input  logic                          fence_i,
  output logic                          inst_valid,
  output logic [YSYX_22051013_INST-1:0] inst_o,
  output logic                          mem_req,
  output logic [YSYX_22051013_PC-1:0]   mem_addr,
  input  logic                          mem_gnt,
  input  logic                          mem_rvalid,
  input  logic [YSYX_22051013_LINE-1:0] mem_rdata
);

  imem_state_e                   state_q, state_d;
  logic                          drop_q, drop_d;
  logic                          buf_v_q, buf_v_d;
  logic [YSYX_22051013_PC-1:0]   req_pc_q, req_pc_d;
  logic [YSYX_22051013_PC-1:0]   buf_pc_q, buf_pc_d;
  logic [YSYX_22051013_LINE-1:0] buf_line_q, buf_line_d;
  logic                          mem_req_q, mem_req_d;
  logic                          hit;

`ifdef ysyx_22051013_IMEM_LBUF_EN
  assign hit = buf_v_q & (buf_pc_q[YSYX_22051013_PC-1:3] == pc_i[YSYX_22051013_PC-1:3]);
`else
  assign hit = buf_v_q & (buf_pc_q == pc_i);
`endif

  assign inst_valid = hit & (state_q == ST_IDLE);
  // A dropped fill leaves stale data in buf_line, so the output is gated on buf_v.
  assign inst_o     = !buf_v_q ? '0 :
                      (pc_i[2] ? buf_line_q[63:32] : buf_line_q[31:0]);
  assign mem_req    = mem_req_q;
  assign mem_addr   = line_addr(req_pc_q);

  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    buf_v_d    = buf_v_q;
    req_pc_d   = req_pc_q;
    buf_pc_d   = buf_pc_q;
    buf_line_d = buf_line_q;
    case (state_q)
      ST_IDLE: begin
        drop_d = 1'b0;
        if (fence_i) begin
          buf_v_d = 1'b0;
        end
        if (!hit) begin
          req_pc_d = pc_i;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (fence_i) begin
          drop_d = 1'b1;
        end
        if (mem_gnt) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (fence_i) begin
          drop_d = 1'b1;
        end
        // A fence coinciding with the return also kills the fill.
        if (mem_rvalid) begin
          buf_line_d = mem_rdata;
          buf_pc_d   = req_pc_q;
          buf_v_d    = ~(drop_q | fence_i);
          drop_d     = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    mem_req_d = (state_d == ST_REQ);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      drop_q     <= 1'b0;
      buf_v_q    <= 1'b0;
      req_pc_q   <= '0;
      buf_pc_q   <= '0;
      buf_line_q <= '0;
      mem_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      drop_q     <= drop_d;
      buf_v_q    <= buf_v_d;
      req_pc_q   <= req_pc_d;
      buf_pc_q   <= buf_pc_d;
      buf_line_q <= buf_line_d;
      mem_req_q  <= mem_req_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22051013_imem_resp.sv
// tb/tb_ysyx_22051013_imem_resp.sv - directed scenarios plus randomized fetch stream against a transaction-level model
module tb_ysyx_22051013_imem_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] pc_i = '0;
  logic        fence_i = 1'b0;
  logic        inst_valid;
  logic [31:0] inst_o;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;

  int n_checks = 0;
  int n_fails  = 0;

  logic        rst_v = 1'b0;
  bit          auto_mem = 1'b0;
  logic        man_gnt = 1'b0;
  logic        man_rv = 1'b0;
  logic [63:0] man_rdata = '0;

  bit          busy = 1'b0;
  bit          ret_now = 1'b0;
  logic [63:0] paddr = '0;
  int          dly = 0;

  ysyx_22051013_imem_resp dut (
    .clk       (clk),
    .rst       (rst),
    .pc_i      (pc_i),
    .fence_i   (fence_i),
    .inst_valid(inst_valid),
    .inst_o    (inst_o),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] line_of(input logic [63:0] a);
    logic [31:0] k;
    k = a[34:3];
    return {(k * 32'h9E3779B1) ^ 32'h5A5A5A5A, (k * 32'h85EBCA77) + 32'h1};
  endfunction

  function automatic logic [31:0] word_of(input logic [63:0] pc);
    logic [63:0] l;
    l = line_of(pc);
    return pc[2] ? l[63:32] : l[31:0];
  endfunction

  function automatic logic [63:0] tag_of(input logic [63:0] pc);
`ifdef ysyx_22051013_IMEM_LBUF_EN
    return {pc[63:3], 3'b000};
`else
    return pc;
`endif
  endfunction

  // One clock: drive inputs just after the edge, sample at the falling edge.
  task automatic step(input logic [63:0] pc, input logic f);
    @(posedge clk);
    #1;
    rst     = rst_v;
    pc_i    = pc;
    fence_i = f;
    if (!auto_mem) begin
      mem_gnt    = man_gnt;
      mem_rvalid = man_rv;
      mem_rdata  = man_rdata;
    end else begin
      if (ret_now) begin
        busy    = 1'b0;
        ret_now = 1'b0;
      end
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = {$urandom, $urandom};
      if (busy) begin
        if (dly == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = line_of(paddr);
          ret_now    = 1'b1;
        end else begin
          dly--;
        end
      end else begin
        if ($urandom_range(0, 3) == 0) mem_rvalid = 1'b1;
        if (mem_req && $urandom_range(0, 2) != 0) begin
          mem_gnt = 1'b1;
          busy    = 1'b1;
          paddr   = mem_addr;
          dly     = $urandom_range(0, 3);
        end
      end
    end
    @(negedge clk);
    if (auto_mem) begin
      if (inst_valid) check_eq("inst_data", 64'(inst_o), 64'(word_of(pc_i)));
      if (mem_req) check_eq("req_addr", mem_addr, {pc_i[63:3], 3'b000});
      if (busy && !mem_gnt) check_eq("one_outstanding", 64'(mem_req), 64'd0);
    end
  endtask

  task automatic mem_set(input logic g, input logic rv, input logic [63:0] d);
    man_gnt   = g;
    man_rv    = rv;
    man_rdata = d;
  endtask

  logic [63:0] model_pc;
  bit          model_v;

  initial begin
    logic [63:0] q;
    bit          f;
    bit          done;
    bit          exp_hit;

    // reset
    rst_v = 1'b0;
    mem_set(0, 0, '0);
    step(64'h0, 0);
    step(64'h8000_0000, 0);
    check_eq("rst_valid", 64'(inst_valid), 0);
    check_eq("rst_inst", 64'(inst_o), 0);
    check_eq("rst_req", 64'(mem_req), 0);

    // basic miss: cycle 0 pc, cycle 1 req+gnt, cycle 2 rvalid, cycle 3 valid
    rst_v = 1'b1;
    step(64'h8000_0000, 0);
    check_eq("miss_c0_req", 64'(mem_req), 0);
    check_eq("miss_c0_valid", 64'(inst_valid), 0);
    mem_set(1, 0, '0);
    step(64'h8000_0000, 0);
    check_eq("miss_c1_req", 64'(mem_req), 1);
    check_eq("miss_c1_addr", mem_addr, 64'h8000_0000);
    mem_set(0, 1, 64'h0000_0013_0010_0093);
    step(64'h8000_0000, 0);
    check_eq("miss_c2_req", 64'(mem_req), 0);
    check_eq("miss_c2_valid", 64'(inst_valid), 0);
    mem_set(0, 0, '0);
    step(64'h8000_0000, 0);
    check_eq("miss_c3_valid", 64'(inst_valid), 1);
    check_eq("miss_c3_inst", 64'(inst_o), 64'h0010_0093);

    // step to next word of the same line
    step(64'h8000_0004, 0);
`ifdef ysyx_22051013_IMEM_LBUF_EN
    check_eq("lbuf_valid", 64'(inst_valid), 1);
    check_eq("lbuf_inst", 64'(inst_o), 64'h0000_0013);
    check_eq("lbuf_noreq", 64'(mem_req), 0);
    step(64'h8000_0004, 0);
    check_eq("lbuf_noreq2", 64'(mem_req), 0);
    check_eq("lbuf_valid2", 64'(inst_valid), 1);
`else
    check_eq("pcbuf_miss", 64'(inst_valid), 0);
    mem_set(1, 0, '0);
    step(64'h8000_0004, 0);
    check_eq("pcbuf_req", 64'(mem_req), 1);
    check_eq("pcbuf_addr", mem_addr, 64'h8000_0000);
    mem_set(0, 1, 64'h0000_0013_0010_0093);
    step(64'h8000_0004, 0);
    mem_set(0, 0, '0);
    step(64'h8000_0004, 0);
    check_eq("pcbuf_valid", 64'(inst_valid), 1);
    check_eq("pcbuf_inst", 64'(inst_o), 64'h0000_0013);
`endif

    // grant stall
    mem_set(0, 0, '0);
    step(64'h8000_0040, 0);
    check_eq("stall_c0_valid", 64'(inst_valid), 0);
    for (int i = 0; i < 5; i++) begin
      step(64'h8000_0040, 0);
      check_eq("stall_req", 64'(mem_req), 1);
      check_eq("stall_addr", mem_addr, 64'h8000_0040);
      check_eq("stall_valid", 64'(inst_valid), 0);
    end
    mem_set(1, 0, '0);
    step(64'h8000_0040, 0);

    // jump while waiting: old line completes, then the new pc is fetched
    mem_set(0, 0, '0);
    step(64'h8000_0100, 0);
    check_eq("jump_wait_req", 64'(mem_req), 0);
    mem_set(0, 1, line_of(64'h8000_0040));
    step(64'h8000_0100, 0);
    check_eq("jump_ret_valid", 64'(inst_valid), 0);
    mem_set(0, 0, '0);
    step(64'h8000_0100, 0);
    check_eq("jump_idle_valid", 64'(inst_valid), 0);
    check_eq("jump_idle_req", 64'(mem_req), 0);
    mem_set(1, 0, '0);
    step(64'h8000_0100, 0);
    check_eq("jump_req", 64'(mem_req), 1);
    check_eq("jump_addr", mem_addr, 64'h8000_0100);
    mem_set(0, 1, line_of(64'h8000_0100));
    step(64'h8000_0100, 0);
    mem_set(0, 0, '0);
    step(64'h8000_0100, 0);
    check_eq("jump_valid", 64'(inst_valid), 1);
    check_eq("jump_inst", 64'(inst_o), 64'(word_of(64'h8000_0100)));

    // fence during wait drops the fill
    step(64'h8000_0200, 0);
    mem_set(1, 0, '0);
    step(64'h8000_0200, 0);
    mem_set(0, 0, '0);
    step(64'h8000_0200, 1);
    mem_set(0, 1, line_of(64'h8000_0200));
    step(64'h8000_0200, 0);
    mem_set(0, 0, '0);
    step(64'h8000_0200, 0);
    check_eq("fence_drop_valid", 64'(inst_valid), 0);
    check_eq("fence_drop_inst", 64'(inst_o), 0);
    mem_set(1, 0, '0);
    step(64'h8000_0200, 0);
    check_eq("fence_refetch_req", 64'(mem_req), 1);
    check_eq("fence_refetch_addr", mem_addr, 64'h8000_0200);
    mem_set(0, 1, line_of(64'h8000_0200));
    step(64'h8000_0200, 0);
    mem_set(0, 0, '0);
    step(64'h8000_0200, 0);
    check_eq("fence_refetch_valid", 64'(inst_valid), 1);

    // reset in wait, then a late return
    step(64'h8000_0300, 0);
    mem_set(1, 0, '0);
    step(64'h8000_0300, 0);
    mem_set(0, 0, '0);
    rst_v = 1'b0;
    step(64'h8000_0300, 0);
    rst_v = 1'b1;
    mem_set(0, 1, 64'hDEAD_BEEF_CAFE_F00D);
    step(64'h8000_0300, 0);
    check_eq("rstwait_req", 64'(mem_req), 0);
    check_eq("rstwait_valid", 64'(inst_valid), 0);
    check_eq("rstwait_inst", 64'(inst_o), 0);
    mem_set(0, 0, '0);
    step(64'h8000_0300, 0);
    check_eq("rstwait_refetch", 64'(mem_req), 1);
    check_eq("rstwait_addr", mem_addr, 64'h8000_0300);
    check_eq("rstwait_valid2", 64'(inst_valid), 0);

    // randomized stream
    rst_v = 1'b0;
    step(64'h8000_0000, 0);
    rst_v    = 1'b1;
    auto_mem = 1'b1;
    busy     = 1'b0;
    ret_now  = 1'b0;
    model_v  = 1'b0;
    model_pc = 64'h8000_0000;
    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 9))
        0, 1:    q = model_pc;
        2, 3, 4: q = model_pc ^ 64'h4;
        default: q = 64'h8000_0000 + 64'({$urandom_range(0, 255), 2'b00});
      endcase
      f = ($urandom_range(0, 9) == 0);
      exp_hit = model_v && (tag_of(q) == tag_of(model_pc));
      step(q, f);
      check_eq("rand_hit", 64'(inst_valid), 64'(exp_hit));
      if (!exp_hit) check_eq("rand_miss_noreq", 64'(mem_req), 0);
      if (f) begin
        step(q, 0);
        check_eq("rand_fence_inval", 64'(inst_valid), 0);
      end
      done = exp_hit && !f;
      for (int w = 0; w < 80 && !done; w++) begin
        f = ($urandom_range(0, 19) == 0);
        step(q, f);
        done = inst_valid && !f;
      end
      if (!done) check_eq("rand_progress", 64'd0, 64'd1);
      model_v  = done;
      model_pc = q;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
